wb_mem_responder: RTL and testbench

WB_MEM_RESPONDER -- requirements
Module: wb_mem_responder

---
 rtl/wb_mem_pkg.sv | 22 ++
 rtl/wb_mem_responder_if.sv | 28 ++
 rtl/wb_mem_array.sv | 36 +++
 rtl/wb_mem_responder.sv | 143 ++++++++++++++
 tb/tb_wb_mem_responder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_mem_pkg.sv
// Shared types and widths for the Wishbone line-memory responder.
// Imported by the interface, the storage array and the top level.
package wb_mem_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 128;
    localparam int WB_SEL_W = 16;
    localparam int CNT_W    = 16;
    localparam int WCNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Down-counter preload for a given number of wait states.
    function automatic logic [WCNT_W-1:0] ws_load(input int ws);
        return (ws > 0) ? WCNT_W'(ws - 1) : '0;
    endfunction

endpackage

// File: rtl/wb_mem_responder_if.sv
// Wishbone bus bundle between a core (master) and the line memory (slave).
// Signal names follow the slave's point of view.
interface wb_mem_responder_if;
    import wb_mem_pkg::*;

    logic [WB_ADR_W-1:0] i_wb_adr;
    logic [WB_SEL_W-1:0] i_wb_sel;
    logic                i_wb_we;
    logic [WB_DAT_W-1:0] i_wb_dat;
    logic [WB_DAT_W-1:0] o_wb_dat;
    logic                i_wb_cyc;
    logic                i_wb_stb;
    logic                o_wb_ack;
    logic                o_wb_err;

    modport master (
        output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat,
        output i_wb_cyc, i_wb_stb,
        input  o_wb_dat, o_wb_ack, o_wb_err
    );

    modport slave (
        input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat,
        input  i_wb_cyc, i_wb_stb,
        output o_wb_dat, o_wb_ack, o_wb_err
    );

endinterface

// File: rtl/wb_mem_array.sv
// Line storage with one byte-enabled write port, a full-line preload
// override and one combinational read port. Contents are never reset.
module wb_mem_array
    import wb_mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                       i_clk,
    input  logic                       i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_line,
    input  logic [WB_SEL_W-1:0]        i_wr_sel,
    input  logic [WB_DAT_W-1:0]        i_wr_data,
    input  logic                       i_ld_en,
    input  logic [$clog2(DEPTH)-1:0]   i_ld_line,
    input  logic [WB_DAT_W-1:0]        i_ld_data,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_line,
    output logic [WB_DAT_W-1:0]        o_rd_data
);

    logic [WB_DAT_W-1:0] mem_q [DEPTH];

    // Bus bytes first, preload last so it overrides every byte of a shared line.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < WB_SEL_W; b++) begin
            if (i_wr_en && i_wr_sel[b]) begin
                mem_q[i_wr_line][8*b +: 8] <= i_wr_data[8*b +: 8];
            end
        end
        if (i_ld_en) begin
            mem_q[i_ld_line] <= i_ld_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_line];

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone slave in front of a byte-enabled line memory: fixed latency of
// WAIT_STATES+1, error on out-of-range lines, abort on cyc drop, preload.
module wb_mem_responder
    import wb_mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    wb_mem_responder_if.slave         wb,
    input  logic                      i_ld_valid,
    input  logic [$clog2(DEPTH)-1:0]  i_ld_line,
    input  logic [WB_DAT_W-1:0]       i_ld_data,
    output logic [CNT_W-1:0]          o_req_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WCNT_W-1:0] WS_LOAD = ws_load(WAIT_STATES);

    state_e              state_q;
    logic [WB_ADR_W-1:4] adr_q, adr_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic                we_q, we_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic [WCNT_W-1:0]   wcnt_q;
    logic                ack_q, err_q;
    logic [WB_DAT_W-1:0] rdat_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept;
    logic                oor;
    logic [AW-1:0]       line;
    logic                wr_en;
    logic                ld_en;
    logic [WB_DAT_W-1:0] rd_data;
    logic                unused_adr_lo;

    // Request fields: live inputs on the accepting cycle, latched copy after.
    always_comb begin
        accept = (state_q == IDLE) && wb.i_wb_cyc && wb.i_wb_stb;
        adr_d  = adr_q;
        sel_d  = sel_q;
        we_d   = we_q;
        dat_d  = dat_q;
        if (accept) begin
            adr_d = wb.i_wb_adr[WB_ADR_W-1:4];
            sel_d = wb.i_wb_sel;
            we_d  = wb.i_wb_we;
            dat_d = wb.i_wb_dat;
        end
        line  = adr_d[AW+3:4];
        oor   = |adr_d[WB_ADR_W-1:AW+4];
        wr_en = (state_q == RESP) && we_q && !oor
                && wb.i_wb_cyc && !i_rst;
        ld_en = i_ld_valid && !i_rst;
    end

    assign unused_adr_lo = ^wb.i_wb_adr[3:0];

    wb_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .i_clk     (i_clk),
        .i_wr_en   (wr_en),
        .i_wr_line (line),
        .i_wr_sel  (sel_q),
        .i_wr_data (dat_q),
        .i_ld_en   (ld_en),
        .i_ld_line (i_ld_line),
        .i_ld_data (i_ld_data),
        .i_rd_line (line),
        .o_rd_data (rd_data)
    );

    // Request latches are plain data holders, updated only on acceptance.
    always_ff @(posedge i_clk) begin
        adr_q <= adr_d;
        sel_q <= sel_d;
        we_q  <= we_d;
        dat_q <= dat_d;
    end

    // Transaction FSM with registered response pulse, read data and counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (WAIT_STATES == 0) begin
                            state_q <= RESP;
                            ack_q   <= !oor;
                            err_q   <= oor;
                            rdat_q  <= (!we_d && !oor) ? rd_data : '0;
                        end else begin
                            state_q <= WAIT;
                            wcnt_q  <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!wb.i_wb_cyc) begin
                        state_q <= IDLE;
                        wcnt_q  <= '0;
                    end else if (wcnt_q == '0) begin
                        state_q <= RESP;
                        ack_q   <= !oor;
                        err_q   <= oor;
                        rdat_q  <= (!we_q && !oor) ? rd_data : '0;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (wb.i_wb_cyc) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A cyc drop during the response cycle suppresses the pulse itself.
    assign wb.o_wb_ack = ack_q & wb.i_wb_cyc;
    assign wb.o_wb_err = err_q & wb.i_wb_cyc;
    assign wb.o_wb_dat = rdat_q;
    assign o_req_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Scoreboard bench: one responder with one wait state, one with three.
// Drivers push expected responses, a negedge monitor pops and compares.
module tb_wb_mem_responder;
    import wb_mem_pkg::*;

    typedef struct {
        logic                err;
        logic [WB_DAT_W-1:0] dat;
        int unsigned         at;
    } exp_t;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    logic ldv1 = 1'b0;
    logic ldv3 = 1'b0;
    logic [7:0] ldl1 = '0;
    logic [7:0] ldl3 = '0;
    logic [WB_DAT_W-1:0] ldd1 = '0;
    logic [WB_DAT_W-1:0] ldd3 = '0;
    logic [CNT_W-1:0] cnt1, cnt3;

    int unsigned ecnt = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt [2] = '{0, 0};
    exp_t sb0 [$];
    exp_t sb1 [$];

    localparam logic [127:0] L0   = {16{8'h0F}};
    localparam logic [127:0] L2   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] L6   = {16{8'h66}};
    localparam logic [127:0] N6   = {8{16'h0606}} ^ {4{32'h00C0FFEE}};
    localparam logic [127:0] D5   = {16{8'hD5}};
    localparam logic [127:0] P5   = {8{16'h55AA}};
    localparam logic [127:0] L255 = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
    localparam logic [127:0] L7   = 128'h7777_0000_1234_5678_9ABC_DEF0_0707_7070;

    wb_mem_responder_if bus1 ();
    wb_mem_responder_if bus3 ();

    wb_mem_responder #(
        .DEPTH       (256),
        .WAIT_STATES (1)
    ) u_dut1 (
        .i_clk      (clk),
        .i_rst      (rst1),
        .wb         (bus1),
        .i_ld_valid (ldv1),
        .i_ld_line  (ldl1),
        .i_ld_data  (ldd1),
        .o_req_cnt  (cnt1)
    );

    wb_mem_responder #(
        .DEPTH       (256),
        .WAIT_STATES (3)
    ) u_dut3 (
        .i_clk      (clk),
        .i_rst      (rst3),
        .wb         (bus3),
        .i_ld_valid (ldv3),
        .i_ld_line  (ldl3),
        .i_ld_data  (ldd3),
        .o_req_cnt  (cnt3)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic set_bus(input int d, input logic cyc, input logic stb,
                           input logic we, input logic [31:0] adr,
                           input logic [15:0] sel, input logic [127:0] dat);
        if (d == 0) begin
            bus1.i_wb_cyc = cyc; bus1.i_wb_stb = stb; bus1.i_wb_we = we;
            bus1.i_wb_adr = adr; bus1.i_wb_sel = sel; bus1.i_wb_dat = dat;
        end else begin
            bus3.i_wb_cyc = cyc; bus3.i_wb_stb = stb; bus3.i_wb_we = we;
            bus3.i_wb_adr = adr; bus3.i_wb_sel = sel; bus3.i_wb_dat = dat;
        end
    endtask

    task automatic set_ld(input int d, input logic v, input logic [7:0] line,
                          input logic [127:0] data);
        if (d == 0) begin
            ldv1 = v; ldl1 = line; ldd1 = data;
        end else begin
            ldv3 = v; ldl3 = line; ldd3 = data;
        end
    endtask

    function automatic logic pulse(input int d);
        if (d == 0) return bus1.o_wb_ack | bus1.o_wb_err;
        return bus3.o_wb_ack | bus3.o_wb_err;
    endfunction

    function automatic logic [15:0] cnt_of(input int d);
        return (d == 0) ? cnt1 : cnt3;
    endfunction

    task automatic mon(input int d, input logic ack, input logic err,
                       input logic [127:0] dat);
        exp_t e;
        int   n;
        chk($sformatf("dut%0d_ack_err_excl", d), 128'(ack & err), '0);
        if (ack | err) begin
            n = (d == 0) ? sb0.size() : sb1.size();
            if (n == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut%0d_spurious got ack=%b err=%b exp none",
                         d, ack, err);
            end else begin
                if (d == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                chk($sformatf("dut%0d_err", d), 128'(err), 128'(e.err));
                chk($sformatf("dut%0d_ack", d), 128'(ack), 128'(!e.err));
                chk($sformatf("dut%0d_rdat", d), dat, e.dat);
                chk($sformatf("dut%0d_latency", d), 128'(ecnt), 128'(e.at));
            end
        end else begin
            chk($sformatf("dut%0d_idle_dat", d), dat, '0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus1.o_wb_ack, bus1.o_wb_err, bus1.o_wb_dat);
        mon(1, bus3.o_wb_ack, bus3.o_wb_err, bus3.o_wb_dat);
    end

    task automatic preload(input int d, input logic [7:0] line,
                           input logic [127:0] data);
        @(posedge clk); #1;
        set_ld(d, 1'b1, line, data);
        @(posedge clk); #1;
        set_ld(d, 1'b0, '0, '0);
    endtask

    // One transaction; optional preload to the same line on the commit edge.
    task automatic req(input int d, input logic we, input logic [31:0] adr,
                       input logic [15:0] sel, input logic [127:0] dat,
                       input logic xerr, input logic [127:0] xdat,
                       input logic ld, input logic [127:0] ldat);
        exp_t e;
        bit   seen = 0;
        int   ws = (d == 0) ? 1 : 3;
        @(posedge clk); #1;
        set_bus(d, 1'b1, 1'b1, we, adr, sel, dat);
        e.err = xerr;
        e.dat = xdat;
        e.at  = ecnt + 1 + ws;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        @(posedge clk); #1;
        set_bus(d, 1'b1, 1'b0, ~we, ~adr, ~sel, ~dat);
        for (int k = 0; k < 16; k++) begin
            if (pulse(d)) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d_timeout got no pulse exp pulse", d);
            if (d == 0) void'(sb0.pop_back());
            else        void'(sb1.pop_back());
        end else begin
            exp_cnt[d]++;
            if (ld) set_ld(d, 1'b1, adr[11:4], ldat);
        end
        @(posedge clk); #1;
        set_ld(d, 1'b0, '0, '0);
        set_bus(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk($sformatf("dut%0d_cnt", d), 128'(cnt_of(d)), 128'(exp_cnt[d]));
    endtask

    initial begin
        set_bus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_bus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst1 = 1'b0;
        rst3 = 1'b0;
        chk("rst_cnt1", 128'(cnt1), '0);
        chk("rst_cnt3", 128'(cnt3), '0);
        chk("rst_ack1", 128'(bus1.o_wb_ack), '0);
        chk("rst_err1", 128'(bus1.o_wb_err), '0);
        chk("rst_dat1", bus1.o_wb_dat, '0);

        preload(0, 8'd0, L0);
        preload(0, 8'd2, L2);
        preload(0, 8'd3, '0);
        preload(0, 8'd6, L6);
        preload(0, 8'd255, L255);

        req(0, 1'b0, 32'h20, 16'hFFFF, '0, 1'b0, L2, 1'b0, '0);
        req(0, 1'b1, 32'h30, 16'h000F, {16{8'hFF}}, 1'b0, '0, 1'b0, '0);
        req(0, 1'b0, 32'h30, '0, '0, 1'b0,
            128'h00000000_00000000_00000000_FFFFFFFF, 1'b0, '0);
        req(0, 1'b1, 32'h34, 16'h8000, {16{8'h5A}}, 1'b0, '0, 1'b0, '0);
        req(0, 1'b0, 32'h3C, '0, '0, 1'b0,
            128'h5A000000_00000000_00000000_FFFFFFFF, 1'b0, '0);

        req(0, 1'b0, 32'h1000, 16'hFFFF, '0, 1'b1, '0, 1'b0, '0);
        req(0, 1'b1, 32'h8000_0000, 16'hFFFF, {16{8'hBB}}, 1'b1, '0,
            1'b0, '0);
        req(0, 1'b0, 32'h00, '0, '0, 1'b0, L0, 1'b0, '0);
        req(0, 1'b0, 32'hFF0, '0, '0, 1'b0, L255, 1'b0, '0);

        req(0, 1'b1, 32'h50, 16'hFFFF, D5, 1'b0, '0, 1'b1, P5);
        req(0, 1'b0, 32'h50, '0, '0, 1'b0, P5, 1'b0, '0);
        req(0, 1'b0, 32'h60, '0, '0, 1'b0, L6, 1'b1, N6);
        req(0, 1'b0, 32'h60, '0, '0, 1'b0, N6, 1'b0, '0);
        req(0, 1'b1, 32'h20, 16'h0000, '0, 1'b0, '0, 1'b0, '0);
        req(0, 1'b0, 32'h20, '0, '0, 1'b0, L2, 1'b0, '0);

        preload(1, 8'd7, L7);
        req(1, 1'b0, 32'h70, '0, '0, 1'b0, L7, 1'b0, '0);

        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b1, 1'b1, 32'h70, 16'hFFFF, '0);
        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b0, 1'b1, 32'h70, 16'hFFFF, '0);
        repeat (2) @(posedge clk);
        #1;
        set_bus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_cnt3", 128'(cnt3), 128'(exp_cnt[1]));
        req(1, 1'b0, 32'h70, '0, '0, 1'b0, L7, 1'b0, '0);

        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b1, 1'b1, 32'h70, 16'hFFFF, '0);
        @(posedge clk); #1;
        rst3 = 1'b1;
        set_ld(1, 1'b1, 8'd7, {16{8'hEE}});
        set_bus(1, 1'b1, 1'b0, 1'b1, 32'h70, 16'hFFFF, '0);
        @(posedge clk); #1;
        rst3 = 1'b0;
        set_ld(1, 1'b0, '0, '0);
        set_bus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        exp_cnt[1] = 0;
        chk("wait_rst_cnt3", 128'(cnt3), '0);
        chk("wait_rst_ack3", 128'(bus3.o_wb_ack), '0);
        repeat (5) @(posedge clk);
        #1;
        req(1, 1'b0, 32'h78, '0, '0, 1'b0, L7, 1'b0, '0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb0_drained", 128'(sb0.size()), '0);
        chk("sb1_drained", 128'(sb1.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
